// File: rtl/cpc_io_mailbox.sv
// Byte mailbox between the CPC Z80 I/O bus and the Teensy MCU port: a TX FIFO (CPC->MCU)
// and an RX FIFO (MCU->CPC), Z80-visible as a data port and a status/control port.
module cpc_io_mailbox #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned AW          = 3,
    parameter logic [15:0] DATA_PORT   = 16'hFBD0,
    parameter logic [15:0] STATUS_PORT = 16'hFBD1,
    parameter logic [15:0] ADDR_MASK   = 16'hFFFF
) (
    input  logic          CLK,
    input  logic          RESET_B,
    input  logic [15:0]   A,
    input  logic [7:0]    D_in,
    output logic [7:0]    D_out,
    output logic          d_oe,
    input  logic          IOREQ_B,
    input  logic          RD_B,
    input  logic          WR_B,
    input  logic          M1_B,
    input  logic          ROMEN_B,
    output logic          romdis_pre,
    input  logic [7:0]    mcu_wdata,
    input  logic          mcu_wr,
    input  logic          mcu_rd,
    output logic [7:0]    mcu_rdata,
    input  logic          mcu_romdis_en,
    output logic [AW:0]   tx_count,
    output logic [AW:0]   rx_count,
    output logic          tx_ovf,
    output logic          rx_unf
);

    localparam logic [AW:0]   L_FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   L_CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] L_PTR_ONE = AW'(1);

    // Bus decode
    logic w_valid;
    logic w_hit_data;
    logic w_hit_stat;
    logic w_wr_data_act;
    logic w_wr_stat_act;
    logic w_rd_data_act;
    logic w_rd_stat_act;

    assign w_valid       = ~IOREQ_B & M1_B;
    assign w_hit_data    = (A & ADDR_MASK) == (DATA_PORT & ADDR_MASK);
    assign w_hit_stat    = (A & ADDR_MASK) == (STATUS_PORT & ADDR_MASK);
    assign w_wr_data_act = w_valid & ~WR_B & w_hit_data;
    assign w_wr_stat_act = w_valid & ~WR_B & w_hit_stat;
    assign w_rd_data_act = w_valid & ~RD_B & w_hit_data;
    assign w_rd_stat_act = w_valid & ~RD_B & w_hit_stat;

    logic r_wr_data_act, r_wr_data_d;
    logic r_wr_stat_act, r_wr_stat_d;
    logic r_rd_data_act, r_rd_data_d;
    logic r_rd_stat_act, r_rd_stat_d;

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_wr_data_act <= 1'b0;
            r_wr_data_d   <= 1'b0;
            r_wr_stat_act <= 1'b0;
            r_wr_stat_d   <= 1'b0;
            r_rd_data_act <= 1'b0;
            r_rd_data_d   <= 1'b0;
            r_rd_stat_act <= 1'b0;
            r_rd_stat_d   <= 1'b0;
        end else begin
            r_wr_data_act <= w_wr_data_act;
            r_wr_data_d   <= r_wr_data_act;
            r_wr_stat_act <= w_wr_stat_act;
            r_wr_stat_d   <= r_wr_stat_act;
            r_rd_data_act <= w_rd_data_act;
            r_rd_data_d   <= r_rd_data_act;
            r_rd_stat_act <= w_rd_stat_act;
            r_rd_stat_d   <= r_rd_stat_act;
        end
    end

    // Write data is captured alongside the decode so it lines up with the event cycle
    logic [7:0] r_din;

    always_ff @(posedge CLK) begin
        r_din <= D_in;
    end

    // Edge-detected events: one per bus cycle however many wait states it has
    logic w_wr_data_ev;
    logic w_wr_stat_ev;
    logic w_rd_data_ev;
    logic w_rd_stat_ev;
    logic w_rd_data_end;
    logic w_flush;

    assign w_wr_data_ev  = r_wr_data_act & ~r_wr_data_d;
    assign w_wr_stat_ev  = r_wr_stat_act & ~r_wr_stat_d;
    assign w_rd_data_ev  = r_rd_data_act & ~r_rd_data_d;
    assign w_rd_stat_ev  = r_rd_stat_act & ~r_rd_stat_d;
    assign w_rd_data_end = ~r_rd_data_act & r_rd_data_d;
    assign w_flush       = w_wr_stat_ev & r_din[7];

    // TX FIFO (CPC -> MCU)
    logic [7:0]    r_tx_mem [DEPTH];
    logic [AW-1:0] r_tx_wr_ptr;
    logic [AW-1:0] r_tx_rd_ptr;
    logic [AW:0]   r_tx_count;
    logic          r_tx_ovf;
    logic          w_tx_empty;
    logic          w_tx_full;
    logic          w_tx_push;
    logic          w_tx_pop;

    assign w_tx_empty = (r_tx_count == '0);
    assign w_tx_full  = (r_tx_count == L_FULL);
    assign w_tx_pop   = mcu_rd & ~w_tx_empty;
    assign w_tx_push  = w_wr_data_ev & (~w_tx_full | w_tx_pop);

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_count  <= '0;
            r_tx_ovf    <= 1'b0;
        end else if (w_flush) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_count  <= '0;
            r_tx_ovf    <= 1'b0;
        end else begin
            if (w_tx_push) begin
                r_tx_wr_ptr <= r_tx_wr_ptr + L_PTR_ONE;
            end
            if (w_tx_pop) begin
                r_tx_rd_ptr <= r_tx_rd_ptr + L_PTR_ONE;
            end
            if (w_tx_push && !w_tx_pop) begin
                r_tx_count <= r_tx_count + L_CNT_ONE;
            end else if (w_tx_pop && !w_tx_push) begin
                r_tx_count <= r_tx_count - L_CNT_ONE;
            end
            if (w_wr_data_ev && !w_tx_push) begin
                r_tx_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr_ptr] <= r_din;
        end
    end

    // RX FIFO (MCU -> CPC)
    logic [7:0]    r_rx_mem [DEPTH];
    logic [AW-1:0] r_rx_wr_ptr;
    logic [AW-1:0] r_rx_rd_ptr;
    logic [AW:0]   r_rx_count;
    logic          r_pop_pend;
    logic          w_rx_empty;
    logic          w_rx_full;
    logic          w_rx_push;
    logic          w_rx_pop;

    assign w_rx_empty = (r_rx_count == '0);
    assign w_rx_full  = (r_rx_count == L_FULL);
    assign w_rx_pop   = w_rd_data_end & r_pop_pend & ~w_rx_empty;
    assign w_rx_push  = mcu_wr & (~w_rx_full | w_rx_pop);

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_count  <= '0;
        end else if (w_flush) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_count  <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_wr_ptr <= r_rx_wr_ptr + L_PTR_ONE;
            end
            if (w_rx_pop) begin
                r_rx_rd_ptr <= r_rx_rd_ptr + L_PTR_ONE;
            end
            if (w_rx_push && !w_rx_pop) begin
                r_rx_count <= r_rx_count + L_CNT_ONE;
            end else if (w_rx_pop && !w_rx_push) begin
                r_rx_count <= r_rx_count - L_CNT_ONE;
            end
        end
    end

    // On a full FIFO the push overwrites the slot being popped; its byte was latched at read start
    always_ff @(posedge CLK) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr_ptr] <= mcu_wdata;
        end
    end

    // Z80 read path: D_out is latched at the start of the bus cycle and held until it ends
    logic [7:0] r_dout;
    logic       r_doe;
    logic       r_rx_unf;
    logic [7:0] w_status;

    assign w_status = {4'b0000, r_rx_unf, r_tx_ovf, w_tx_full, ~w_rx_empty};

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_dout     <= 8'h00;
            r_doe      <= 1'b0;
            r_rx_unf   <= 1'b0;
            r_pop_pend <= 1'b0;
        end else begin
            r_doe <= r_rd_data_act | r_rd_stat_act;
            if (w_rd_data_ev) begin
                r_dout     <= w_rx_empty ? 8'hFF : r_rx_mem[r_rx_rd_ptr];
                r_pop_pend <= ~w_rx_empty;
                if (w_rx_empty) begin
                    r_rx_unf <= 1'b1;
                end
            end else if (w_rd_stat_ev) begin
                r_dout <= w_status;
            end
            if (w_rd_data_end) begin
                r_pop_pend <= 1'b0;
            end
            if (w_flush) begin
                r_rx_unf   <= 1'b0;
                r_pop_pend <= 1'b0;
            end
        end
    end

    assign D_out      = r_dout;
    assign d_oe       = r_doe;
    assign mcu_rdata  = w_tx_empty ? 8'hFF : r_tx_mem[r_tx_rd_ptr];
    assign tx_count   = r_tx_count;
    assign rx_count   = r_rx_count;
    assign tx_ovf     = r_tx_ovf;
    assign rx_unf     = r_rx_unf;
    // Unregistered on purpose: ROMDIS must follow ROMEN_B within the same bus cycle
    assign romdis_pre = mcu_romdis_en & ~ROMEN_B;

endmodule

// File: tb/tb_cpc_io_mailbox.sv
// Scoreboard bench for cpc_io_mailbox: stimulus queues expected read bytes, a monitor
// compares them when d_oe rises (CPC side) or when mcu_rd is pulsed (MCU side).
module tb_cpc_io_mailbox;

    localparam int          DEPTH = 8;
    localparam int          AW    = 3;
    localparam logic [15:0] DP    = 16'hFBD0;
    localparam logic [15:0] SP    = 16'hFBD1;

    logic          CLK;
    logic          RESET_B;
    logic [15:0]   A;
    logic [7:0]    D_in;
    logic [7:0]    D_out;
    logic          d_oe;
    logic          IOREQ_B, RD_B, WR_B, M1_B, ROMEN_B;
    logic          romdis_pre;
    logic [7:0]    mcu_wdata;
    logic          mcu_wr, mcu_rd;
    logic [7:0]    mcu_rdata;
    logic          mcu_romdis_en;
    logic [AW:0]   tx_count, rx_count;
    logic          tx_ovf, rx_unf;

    cpc_io_mailbox #(
        .DEPTH(DEPTH), .AW(AW), .DATA_PORT(DP), .STATUS_PORT(SP), .ADDR_MASK(16'hFFFF)
    ) dut (
        .CLK(CLK), .RESET_B(RESET_B), .A(A), .D_in(D_in), .D_out(D_out), .d_oe(d_oe),
        .IOREQ_B(IOREQ_B), .RD_B(RD_B), .WR_B(WR_B), .M1_B(M1_B), .ROMEN_B(ROMEN_B),
        .romdis_pre(romdis_pre), .mcu_wdata(mcu_wdata), .mcu_wr(mcu_wr), .mcu_rd(mcu_rd),
        .mcu_rdata(mcu_rdata), .mcu_romdis_en(mcu_romdis_en),
        .tx_count(tx_count), .rx_count(rx_count), .tx_ovf(tx_ovf), .rx_unf(rx_unf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] cpc_q[$];
    logic [7:0] mcu_q[$];
    logic       mon_prev_doe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: consumes expected bytes whenever the DUT presents read data
    initial begin
        logic [7:0] e;
        mon_prev_doe = 1'b0;
        forever begin
            @(negedge CLK);
            if (d_oe === 1'b1 && !mon_prev_doe) begin
                if (cpc_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL cpc_unexpected_read: got d_oe=1 D_out=%0h, expected no read", D_out);
                end else begin
                    e = cpc_q.pop_front();
                    check("cpc_read", {24'd0, D_out}, {24'd0, e});
                end
            end
            mon_prev_doe = (d_oe === 1'b1);
            if (mcu_rd) begin
                if (mcu_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL mcu_unexpected_pop: got mcu_rdata=%0h, expected no pop", mcu_rdata);
                end else begin
                    e = mcu_q.pop_front();
                    check("mcu_rdata", {24'd0, mcu_rdata}, {24'd0, e});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic io_write(input logic [15:0] addr, input logic [7:0] data);
        A = addr; D_in = data; IOREQ_B = 1'b0; WR_B = 1'b0;
        tick(3);
        IOREQ_B = 1'b1; WR_B = 1'b1;
        tick(3);
    endtask

    task automatic io_read(input logic [15:0] addr, input logic expect_data, input logic [7:0] exp);
        if (expect_data) cpc_q.push_back(exp);
        A = addr; IOREQ_B = 1'b0; RD_B = 1'b0;
        tick(3);
        IOREQ_B = 1'b1; RD_B = 1'b1;
        tick(3);
    endtask

    task automatic mcu_push(input logic [7:0] data);
        mcu_wdata = data; mcu_wr = 1'b1;
        tick(1);
        mcu_wr = 1'b0;
    endtask

    task automatic mcu_pop(input logic [7:0] exp);
        mcu_q.push_back(exp);
        mcu_rd = 1'b1;
        tick(1);
        mcu_rd = 1'b0;
    endtask

    initial begin
        RESET_B = 1'b0; A = 16'h0000; D_in = 8'h00;
        IOREQ_B = 1'b1; RD_B = 1'b1; WR_B = 1'b1; M1_B = 1'b1; ROMEN_B = 1'b1;
        mcu_wdata = 8'h00; mcu_wr = 1'b0; mcu_rd = 1'b0; mcu_romdis_en = 1'b0;
        tick(2);
        check("rst_dout", {24'd0, D_out}, 32'h00);
        check("rst_doe", {31'd0, d_oe}, 32'd0);
        check("rst_tx_count", {28'd0, tx_count}, 32'd0);
        check("rst_rx_count", {28'd0, rx_count}, 32'd0);
        check("rst_flags", {30'd0, tx_ovf, rx_unf}, 32'd0);
        check("rst_mcu_rdata", {24'd0, mcu_rdata}, 32'hFF);
        RESET_B = 1'b1;
        tick(1);

        // Status read after reset, with d_oe timing
        cpc_q.push_back(8'h00);
        A = SP; IOREQ_B = 1'b0; RD_B = 1'b0;
        tick(1);
        check("doe_not_yet", {31'd0, d_oe}, 32'd0);
        tick(1);
        check("doe_rise", {31'd0, d_oe}, 32'd1);
        tick(1);
        IOREQ_B = 1'b1; RD_B = 1'b1;
        tick(1);
        check("doe_held", {31'd0, d_oe}, 32'd1);
        tick(1);
        check("doe_drop", {31'd0, d_oe}, 32'd0);
        tick(1);

        // TX write latency and MCU drain
        A = DP; D_in = 8'h11; IOREQ_B = 1'b0; WR_B = 1'b0;
        tick(1);
        check("wr_lat_before", {28'd0, tx_count}, 32'd0);
        tick(1);
        check("wr_lat_count", {28'd0, tx_count}, 32'd1);
        check("wr_lat_rdata", {24'd0, mcu_rdata}, 32'h11);
        tick(1);
        IOREQ_B = 1'b1; WR_B = 1'b1;
        tick(3);
        io_write(DP, 8'h22);
        io_write(DP, 8'h33);
        check("tx_count_3", {28'd0, tx_count}, 32'd3);
        mcu_pop(8'h11);
        mcu_pop(8'h22);
        check("tx_count_1", {28'd0, tx_count}, 32'd1);
        mcu_pop(8'h33);
        mcu_pop(8'hFF);
        check("tx_count_0", {28'd0, tx_count}, 32'd0);

        // TX overflow
        for (int i = 0; i < DEPTH; i++) io_write(DP, 8'(i + 1));
        io_write(DP, 8'hAA);
        check("tx_full_count", {28'd0, tx_count}, DEPTH);
        check("tx_ovf_set", {31'd0, tx_ovf}, 32'd1);
        io_read(SP, 1'b1, 8'h06);
        for (int i = 0; i < DEPTH; i++) mcu_pop(8'(i + 1));
        mcu_pop(8'hFF);
        check("tx_ovf_sticky", {31'd0, tx_ovf}, 32'd1);
        io_write(SP, 8'h80);
        check("tx_ovf_cleared", {31'd0, tx_ovf}, 32'd0);

        // RX full with same-cycle push and CPC pop
        for (int i = 0; i < DEPTH; i++) mcu_push(8'hB0 + 8'(i));
        mcu_push(8'hEE);
        check("rx_full_count", {28'd0, rx_count}, DEPTH);
        check("rx_full_no_unf", {31'd0, rx_unf}, 32'd0);
        cpc_q.push_back(8'hB0);
        A = DP; IOREQ_B = 1'b0; RD_B = 1'b0;
        tick(3);
        IOREQ_B = 1'b1; RD_B = 1'b1;
        tick(1);
        mcu_wdata = 8'hC5; mcu_wr = 1'b1;
        tick(1);
        mcu_wr = 1'b0;
        check("rx_simul_count", {28'd0, rx_count}, DEPTH);
        tick(1);
        for (int i = 1; i < DEPTH; i++) io_read(DP, 1'b1, 8'hB0 + 8'(i));
        io_read(DP, 1'b1, 8'hC5);
        check("rx_drained", {28'd0, rx_count}, 32'd0);

        // Pointer wrap over 3*DEPTH bytes
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 6; i++) mcu_push(8'h40 + 8'(b * 6 + i));
            for (int i = 0; i < 6; i++) io_read(DP, 1'b1, 8'h40 + 8'(b * 6 + i));
        end
        check("wrap_count", {28'd0, rx_count}, 32'd0);
        check("wrap_no_unf", {31'd0, rx_unf}, 32'd0);

        // RX underflow and flush
        io_read(DP, 1'b1, 8'hFF);
        check("unf_set", {31'd0, rx_unf}, 32'd1);
        check("unf_count", {28'd0, rx_count}, 32'd0);
        io_read(SP, 1'b1, 8'h08);
        io_write(DP, 8'h55);
        mcu_push(8'h66);
        mcu_push(8'h77);
        io_write(SP, 8'h7F);
        check("noflush_tx", {28'd0, tx_count}, 32'd1);
        check("noflush_rx", {28'd0, rx_count}, 32'd2);
        io_read(SP, 1'b1, 8'h09);
        io_write(SP, 8'h80);
        check("flush_tx", {28'd0, tx_count}, 32'd0);
        check("flush_rx", {28'd0, rx_count}, 32'd0);
        check("flush_unf", {31'd0, rx_unf}, 32'd0);
        check("flush_rdata", {24'd0, mcu_rdata}, 32'hFF);

        // ROMDIS and ignored cycles
        mcu_romdis_en = 1'b1; ROMEN_B = 1'b0; #1;
        check("romdis_on", {31'd0, romdis_pre}, 32'd1);
        ROMEN_B = 1'b1; #1;
        check("romdis_romen_hi", {31'd0, romdis_pre}, 32'd0);
        ROMEN_B = 1'b0; #1;
        check("romdis_on2", {31'd0, romdis_pre}, 32'd1);
        mcu_romdis_en = 1'b0; #1;
        check("romdis_off", {31'd0, romdis_pre}, 32'd0);
        ROMEN_B = 1'b1;
        tick(1);
        A = DP; D_in = 8'h99; IOREQ_B = 1'b0; M1_B = 1'b0; WR_B = 1'b0;
        tick(3);
        IOREQ_B = 1'b1; M1_B = 1'b1; WR_B = 1'b1;
        tick(3);
        check("intack_no_push", {28'd0, tx_count}, 32'd0);
        io_write(16'hFBD2, 8'h5A);
        check("unmatched_no_push", {28'd0, tx_count}, 32'd0);
        io_read(16'hFBD2, 1'b0, 8'h00);
        check("unmatched_no_doe", {31'd0, d_oe}, 32'd0);

        // Asynchronous reset mid-cycle
        io_write(DP, 8'h12);
        mcu_push(8'h34);
        io_read(SP, 1'b1, 8'h01);
        check("pre_rst_tx", {28'd0, tx_count}, 32'd1);
        @(negedge CLK);
        #2 RESET_B = 1'b0;
        #1;
        check("async_rst_tx", {28'd0, tx_count}, 32'd0);
        check("async_rst_rx", {28'd0, rx_count}, 32'd0);
        check("async_rst_dout", {24'd0, D_out}, 32'h00);
        check("async_rst_rdata", {24'd0, mcu_rdata}, 32'hFF);
        tick(2);
        RESET_B = 1'b1;
        tick(2);

        check("cpc_q_drained", cpc_q.size(), 32'd0);
        check("mcu_q_drained", mcu_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpc_io_mailbox.md
# cpc_io_mailbox

Parametrised CPLD mailbox between the CPC expansion bus and the Teensy MCU port on the CPLD/Teensy multiface card. It holds two byte FIFOs of depth DEPTH: CPC→MCU (TX) and MCU→CPC (RX). Both are exposed to the Z80 as a data port and a status/control port at parametrised I/O addresses. It also gates the ROMDIS pre-driver under MCU control. The block sits in the XC9572-class CPLD, clocked by the CPC bus clock, with the MCU-side strobes already synchronised to CLK.

## Interface
Parameters:
- DEPTH, 8: FIFO depth in bytes per direction; power of two, 2..64.
- AW, 3: log2(DEPTH).
- DATA_PORT, 16'hFBD0: Z80 I/O address of the data port.
- STATUS_PORT, 16'hFBD1: Z80 I/O address of the status/control port.
- ADDR_MASK, 16'hFFFF: address bits compared when decoding both ports.

Ports:
- CLK  in  1  CPC bus clock; all state changes on its rising edge.
- RESET_B  in  1  asynchronous, active-low reset.
- A  in  16  Z80 address.
- D_in  in  8  Z80 data bus, input path.
- D_out  out  8  data driven onto the Z80 bus.
- d_oe  out  1  tri-state enable for D_out.
- IOREQ_B, RD_B, WR_B, M1_B  in  1 each  Z80 strobes.
- ROMEN_B  in  1  CPC ROM enable.
- romdis_pre  out  1  ROMDIS pre-driver; leaves the board through a diode.
- mcu_wdata  in  8  byte to push into RX.
- mcu_wr  in  1  one-cycle push pulse into RX.
- mcu_rd  in  1  one-cycle pop pulse from TX.
- mcu_rdata  out  8  head of TX; 8'hFF when TX is empty.
- mcu_romdis_en  in  1  MCU request to disable the internal ROM.
- tx_count, rx_count  out  AW+1 each  current FIFO occupancy.
- tx_ovf, rx_unf  out  1 each  sticky error flags.

## Operation
- A valid I/O cycle is ~IOREQ_B & M1_B. Interrupt acknowledge (IOREQ_B and M1_B both low) is ignored.
- A port matches when (A & ADDR_MASK) == (PORT & ADDR_MASK).
- Decodes are registered each cycle: wr_act = valid & ~WR_B & match; rd_act = valid & ~RD_B & match.
- Events fire on the first cycle an act term is high and its registered previous value is low. One event is produced per bus cycle, regardless of wait states.
- Data-port write: push D_in into TX. If TX is full, drop the byte and set tx_ovf.
- Status-port write: if D_in[7]=1, empty both FIFOs (pointers and counts to 0) and clear tx_ovf and rx_unf. Other bits are ignored.
- Data-port read: D_out is latched with the RX head, or 8'hFF if RX is empty (which also sets rx_unf). The RX pop happens on the cycle rd_act falls, and only if RX was non-empty at latch time.
- Status-port read: D_out = {4'b0, rx_unf, tx_ovf, tx_count==DEPTH, rx_count!=0}.
- MCU side: mcu_wr pushes into RX, and is dropped silently if RX is full. mcu_rd pops TX, and is ignored if TX is empty.
- Simultaneous push and pop on the same FIFO in the same cycle:
  - both take effect and the count is unchanged;
  - this is allowed when the FIFO is full (the pop frees the slot);
  - when the FIFO is empty, only the push takes effect.
- A flush has priority over a same-cycle push or pop.
- Pointers are AW bits and wrap modulo DEPTH. Counts are AW+1 bits, saturating at DEPTH.
- romdis_pre = mcu_romdis_en & ~ROMEN_B. This is the only combinational path and is not registered.

## Timing
- Reset values:
  - D_out = 8'h00, d_oe = 0, romdis_pre follows its inputs;
  - counts = 0, pointers = 0;
  - tx_ovf = rx_unf = 0;
  - mcu_rdata = 8'hFF.
- Reset asserted mid-cycle clears everything immediately; FIFO contents are don't-care.
- Write latency: TX push on edge N+1 after wr_act is first sampled at edge N. tx_count and mcu_rdata update at edge N+1.
- Read timing:
  - d_oe rises one cycle after rd_act is first sampled, with D_out valid in the same cycle;
  - d_oe is held while rd_act = 1 and drops the cycle after rd_act falls;
  - the pop lands on that same edge.
- MCU latency: mcu_wr and mcu_rd act on the edge they are sampled high. rx_count and mcu_rdata are valid the next cycle.
- A read or write to an unmatched port produces no state change and leaves d_oe = 0.

## Test plan
- Reset, then read STATUS_PORT → D_out=8'h00, d_oe pulse only during the read, both counts 0.
- CPC writes 8'h11, 8'h22, 8'h33 to DATA_PORT; MCU pulses mcu_rd 3x → mcu_rdata 11, 22, 33, then FF; tx_count goes 3→0.
- Fill TX with DEPTH writes plus one extra write of 8'hAA → tx_count=DEPTH, tx_ovf=1, 8'hAA never appears at mcu_rdata; status bit1=1.
- RX full, same-cycle mcu_wr and CPC data read → count stays DEPTH, the read returns the oldest byte, and the new byte is appended last; pointer wrap is verified over 3·DEPTH bytes in order.
- CPC reads DATA_PORT with RX empty → D_out=8'hFF, rx_unf=1; a status write of 8'h80 clears rx_unf and empties both FIFOs.
- mcu_romdis_en=1 with ROMEN_B toggling → romdis_pre mirrors ~ROMEN_B in the same cycle; an IOREQ_B+M1_B-low cycle at DATA_PORT causes no push.
